// File: rtl/fir_multichannel.sv
// fir_multichannel: time-multiplexed multi-channel FIR, one shared signed MAC, runtime-loadable coefficients.
// Latency: outputValid strobes TAPS+2 cycles after the input handshake (TAPS+1 MAC cycles, then DONE).
// Backpressure: inputReady is high only in IDLE, so at most one sample is accepted per TAPS+3 cycles.
// Optional build macro FIR_SATURATE_EN: clamp instead of wrap when the result is narrowed to OutputWidth.
module fir_multichannel #(
    parameter int InputWidth  = 16,
    parameter int CoefWidth   = 16,
    parameter int OutputWidth = 38,
    parameter int TAPS        = 64,
    parameter int CHANNELS    = 4
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              inputValid,
    output logic                                              inputReady,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] inputChannel,
    input  logic signed [InputWidth-1:0]                      FIR_input,
    input  logic                                              coefWe,
    input  logic [$clog2(TAPS)-1:0]                           coefAddr,
    input  logic signed [CoefWidth-1:0]                       coefData,
    output logic                                              outputValid,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] outputChannel,
    output logic signed [OutputWidth-1:0]                     FIR_output
);

    localparam int CHW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int AW   = $clog2(TAPS);
    localparam int HN   = CHANNELS * TAPS;
    localparam int HAW  = (HN > 1) ? $clog2(HN) : 1;
    localparam int PW   = InputWidth + CoefWidth;
    localparam int ACCW = InputWidth + CoefWidth + AW;

    typedef enum logic [1:0] {CLEAR, IDLE, MAC, DONE} state_t;

    state_t r_state;
    state_t w_next;

    // Sample histories of all channels share one array; channel c owns entries c*TAPS .. c*TAPS+TAPS-1.
    logic signed [InputWidth-1:0] r_hist [HN];
    logic signed [CoefWidth-1:0]  r_coef [TAPS];
    // Per-channel head: the slot the next sample of that channel will be written to.
    logic [AW-1:0]                r_head [CHANNELS];

    logic [HAW-1:0]               r_clr_idx;
    logic [CHW-1:0]               r_ch;
    logic [AW-1:0]                r_rd_idx;
    logic [AW:0]                  r_tap;
    logic signed [InputWidth-1:0] r_x;
    logic signed [CoefWidth-1:0]  r_c;
    logic signed [ACCW-1:0]       r_acc;
    logic signed [OutputWidth-1:0] r_out;
    logic [CHW-1:0]               r_out_ch;

    logic                         w_hs;
    logic                         w_ch_ok;
    logic                         w_accept;
    logic                         w_clr_last;
    logic                         w_mac_last;
    logic                         w_hist_we;
    logic [HAW-1:0]               w_hist_addr;
    logic [HAW-1:0]               w_rd_addr;
    logic signed [InputWidth-1:0] w_hist_dat;
    logic signed [PW-1:0]         w_prod;
    logic signed [ACCW-1:0]       w_sum;
    logic signed [OutputWidth-1:0] w_result;

    assign w_hs       = inputValid && (r_state == IDLE);
    assign w_ch_ok    = (32'(inputChannel) < 32'(CHANNELS));
    assign w_accept   = w_hs && w_ch_ok;
    assign w_clr_last = (r_clr_idx == HAW'(HN - 1));
    assign w_mac_last = (r_tap == (AW + 1)'(TAPS));

    // Single history write port: zero fill during CLEAR, otherwise the accepted sample at its channel head.
    assign w_hist_we   = !rst && ((r_state == CLEAR) || w_accept);
    assign w_hist_addr = (r_state == CLEAR) ? r_clr_idx
                       : HAW'(inputChannel) * HAW'(TAPS) + HAW'(r_head[inputChannel]);
    assign w_hist_dat  = (r_state == CLEAR) ? '0 : FIR_input;
    assign w_rd_addr   = HAW'(r_ch) * HAW'(TAPS) + HAW'(r_rd_idx);

    // Accumulator is wide enough for TAPS full-scale products, so it can never overflow.
    assign w_prod = PW'(r_x) * PW'(r_c);
    assign w_sum  = r_acc + ACCW'(w_prod);

    // Narrowing of the final sum to the output width.
    generate
        if (OutputWidth >= ACCW) begin : g_ext
            assign w_result = OutputWidth'(w_sum);
        end else begin : g_narrow
`ifdef FIR_SATURATE_EN
            logic w_fits;
            assign w_fits   = (&w_sum[ACCW-1:OutputWidth-1]) | ~(|w_sum[ACCW-1:OutputWidth-1]);
            assign w_result = w_fits ? w_sum[OutputWidth-1:0]
                            : (w_sum[ACCW-1] ? {1'b1, {(OutputWidth-1){1'b0}}}
                                             : {1'b0, {(OutputWidth-1){1'b1}}});
`else
            assign w_result = w_sum[OutputWidth-1:0];
`endif
        end
    endgenerate

    // History storage: no reset, contents are zeroed by the CLEAR sweep instead.
    always_ff @(posedge clk) begin
        if (w_hist_we) begin
            r_hist[w_hist_addr] <= w_hist_dat;
        end
    end

    // Coefficient storage: survives reset, writable only while IDLE.
    always_ff @(posedge clk) begin
        if (!rst && coefWe && (r_state == IDLE)) begin
            r_coef[coefAddr] <= coefData;
        end
    end

    // State register; reset always restarts the history clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake/strobe outputs.
    always_comb begin
        w_next      = r_state;
        inputReady  = 1'b0;
        outputValid = 1'b0;
        case (r_state)
            CLEAR: begin
                if (w_clr_last) begin
                    w_next = IDLE;
                end
            end
            IDLE: begin
                inputReady = 1'b1;
                if (w_accept) begin
                    w_next = MAC;
                end
            end
            MAC: begin
                if (w_mac_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                outputValid = 1'b1;
                w_next      = IDLE;
            end
            default: w_next = CLEAR;
        endcase
    end

    // Datapath: clear sweep, head pointers, registered tap reads, accumulation and result capture.
    // MAC cycle t reads tap t (t < TAPS) and accumulates product t-1 (t > 0), hence TAPS+1 cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_idx <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_head[i] <= '0;
            end
            r_ch     <= '0;
            r_rd_idx <= '0;
            r_tap    <= '0;
            r_x      <= '0;
            r_c      <= '0;
            r_acc    <= '0;
            r_out    <= '0;
            r_out_ch <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_clr_idx <= r_clr_idx + HAW'(1);
                end
                IDLE: begin
                    if (w_accept) begin
                        r_head[inputChannel] <= (r_head[inputChannel] == AW'(TAPS - 1)) ? '0
                                              : r_head[inputChannel] + AW'(1);
                        r_ch     <= inputChannel;
                        r_rd_idx <= r_head[inputChannel];
                        r_tap    <= '0;
                        r_acc    <= '0;
                    end
                end
                MAC: begin
                    if (!w_mac_last) begin
                        r_x      <= r_hist[w_rd_addr];
                        r_c      <= r_coef[r_tap[AW-1:0]];
                        r_rd_idx <= (r_rd_idx == '0) ? AW'(TAPS - 1) : r_rd_idx - AW'(1);
                    end
                    if (r_tap != '0) begin
                        r_acc <= w_sum;
                    end
                    r_tap <= r_tap + (AW + 1)'(1);
                    if (w_mac_last) begin
                        r_out    <= w_result;
                        r_out_ch <= r_ch;
                    end
                end
                default: ;
            endcase
        end
    end

    assign FIR_output    = r_out;
    assign outputChannel = r_out_ch;

endmodule

// File: tb/tb_fir_multichannel.sv
// Bench for fir_multichannel: two instances share one stimulus bus.
// dut0: TAPS=4, CHANNELS=4, 38-bit output. dut1: TAPS=4, CHANNELS=3, 16-bit output.
// A behavioural convolution model fills per-instance expectation queues; monitors pop and compare.
module tb_fir_multichannel;

    localparam int T = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst0, rst1;
    logic        in_vld, c_we;
    int          sel;
    logic [1:0]  in_ch, c_addr;
    logic [15:0] in_dat, c_dat;

    wire v0  = in_vld && (sel == 0);
    wire v1  = in_vld && (sel == 1);
    wire we0 = c_we && (sel == 0);
    wire we1 = c_we && (sel == 1);

    logic        rdy0, vld0, rdy1, vld1;
    logic [1:0]  och0, och1;
    logic [37:0] out0;
    logic [15:0] out1;

    fir_multichannel #(.InputWidth(16), .CoefWidth(16), .OutputWidth(38), .TAPS(T), .CHANNELS(4)) dut0 (
        .clk(clk), .rst(rst0), .inputValid(v0), .inputReady(rdy0), .inputChannel(in_ch),
        .FIR_input(in_dat), .coefWe(we0), .coefAddr(c_addr), .coefData(c_dat),
        .outputValid(vld0), .outputChannel(och0), .FIR_output(out0));

    fir_multichannel #(.InputWidth(16), .CoefWidth(16), .OutputWidth(16), .TAPS(T), .CHANNELS(3)) dut1 (
        .clk(clk), .rst(rst1), .inputValid(v1), .inputReady(rdy1), .inputChannel(in_ch),
        .FIR_input(in_dat), .coefWe(we1), .coefAddr(c_addr), .coefData(c_dat),
        .outputValid(vld1), .outputChannel(och1), .FIR_output(out1));

    typedef struct {
        int     e_ch;
        longint e_val;
        int     e_hs;
    } exp_t;

    exp_t   q0[$];
    exp_t   q1[$];
    exp_t   e0, e1;
    longint c0[4], c1[4];
    longint h0[4][4];
    longint h1[3][4];
    int     vectors = 0;
    int     miscompares = 0;
    int     nout0 = 0;
    int     nout1 = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // 16-bit output of dut1: clamp or two's-complement wrap depending on the build.
    function automatic longint narrow16(input longint v);
`ifdef FIR_SATURATE_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        logic signed [15:0] t;
        t = v[15:0];
        return longint'(t);
`endif
    endfunction

    // Monitors: strobe seen at negedge after edge E+T+1 when the handshake happened at edge E.
    always @(negedge clk) begin
        if (vld0) begin
            nout0++;
            if (q0.size() == 0) begin
                chk("unexpected_out0", 1, 0);
            end else begin
                e0 = q0.pop_front();
                chk("out0_value", $signed(out0), e0.e_val);
                chk("out0_channel", och0, e0.e_ch);
                chk("out0_latency", cyc - e0.e_hs, T + 1);
            end
        end
    end

    always @(negedge clk) begin
        if (vld1) begin
            nout1++;
            if (q1.size() == 0) begin
                chk("unexpected_out1", 1, 0);
            end else begin
                e1 = q1.pop_front();
                chk("out1_value", $signed(out1), e1.e_val);
                chk("out1_channel", och1, e1.e_ch);
                chk("out1_latency", cyc - e1.e_hs, T + 1);
            end
        end
    end

    // All tasks start and end at a negedge.
    task automatic wcoef(input int s, input int a, input int d, input bit upd);
        sel    = s;
        c_we   = 1'b1;
        c_addr = a[1:0];
        c_dat  = d[15:0];
        if (upd) begin
            if (s == 0) c0[a] = d;
            else        c1[a] = d;
        end
        @(negedge clk);
        c_we = 1'b0;
    endtask

    task automatic send(input int s, input int ch, input int x, input bit wc, input int ca, input int cd);
        int     n;
        longint y;
        n   = 0;
        sel = s;
        while ((((s == 0) ? rdy0 : rdy1) !== 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_send", (s == 0) ? rdy0 : rdy1, 1);
        in_vld = 1'b1;
        in_ch  = ch[1:0];
        in_dat = x[15:0];
        if (wc) begin
            c_we   = 1'b1;
            c_addr = ca[1:0];
            c_dat  = cd[15:0];
            if (s == 0) c0[ca] = cd;
            else        c1[ca] = cd;
        end
        y = 0;
        if (s == 0) begin
            for (int k = T - 1; k > 0; k--) h0[ch][k] = h0[ch][k-1];
            h0[ch][0] = x;
            for (int k = 0; k < T; k++) y += c0[k] * h0[ch][k];
            q0.push_back('{e_ch: ch, e_val: y, e_hs: cyc + 1});
        end else if (ch < 3) begin
            for (int k = T - 1; k > 0; k--) h1[ch][k] = h1[ch][k-1];
            h1[ch][0] = x;
            for (int k = 0; k < T; k++) y += c1[k] * h1[ch][k];
            q1.push_back('{e_ch: ch, e_val: narrow16(y), e_hs: cyc + 1});
        end
        @(negedge clk);
        in_vld = 1'b0;
        c_we   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && rdy0 === 1'b1 && rdy1 === 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_outstanding", q0.size() + q1.size(), 0);
    endtask

    // Edges from the last reset edge until inputReady first reads high.
    task automatic clear_len(input int s, input int exp, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((((s == 0) ? rdy0 : rdy1) !== 1'b1) && n < 500);
        chk(tag, n, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, n0, n1, nb;
        rst0 = 1'b1; rst1 = 1'b1;
        in_vld = 1'b0; c_we = 1'b0; sel = 0;
        in_ch = '0; c_addr = '0; in_dat = '0; c_dat = '0;
        for (int i = 0; i < 4; i++) begin
            c0[i] = 0; c1[i] = 0;
            for (int k = 0; k < T; k++) h0[i][k] = 0;
        end
        for (int i = 0; i < 3; i++) for (int k = 0; k < T; k++) h1[i][k] = 0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ready0", rdy0, 0);
        chk("rst_valid0", vld0, 0);
        chk("rst_chan0", och0, 0);
        chk("rst_out0", $signed(out0), 0);
        chk("rst_ready1", rdy1, 0);
        chk("rst_valid1", vld1, 0);
        chk("rst_chan1", och1, 0);
        chk("rst_out1", $signed(out1), 0);

        // Clear sweep length: CHANNELS*TAPS cycles
        rst0 = 1'b0; rst1 = 1'b0;
        n = 0; n0 = -1; n1 = -1;
        while ((n0 < 0 || n1 < 0) && n < 200) begin
            @(negedge clk);
            n++;
            if (n0 < 0 && rdy0 === 1'b1) n0 = n;
            if (n1 < 0 && rdy1 === 1'b1) n1 = n;
        end
        chk("clear_len0", n0, 16);
        chk("clear_len1", n1, 12);

        // Impulse response with coefficients 1,2,3,4
        for (int k = 0; k < T; k++) wcoef(0, k, k + 1, 1'b1);
        send(0, 0, 1, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) send(0, 0, 0, 1'b0, 0, 0);
        drain();

        // Channel isolation with all-ones coefficients
        for (int k = 0; k < T; k++) wcoef(0, k, 1, 1'b1);
        send(0, 0, 1, 1'b0, 0, 0);
        send(0, 1, 100, 1'b0, 0, 0);
        send(0, 0, 0, 1'b0, 0, 0);
        send(0, 0, 0, 1'b0, 0, 0);
        send(0, 0, 0, 1'b0, 0, 0);
        drain();

        // Coefficient write during MAC is ignored
        send(0, 2, 5, 1'b0, 0, 0);
        wcoef(0, 0, 7, 1'b0);
        drain();
        // Same write together with a handshake takes effect for that sample
        send(0, 2, 3, 1'b1, 0, 7);
        drain();

        // Reset three cycles after a handshake aborts the MAC
        send(0, 3, 9, 1'b0, 0, 0);
        @(negedge clk);
        rst0 = 1'b1;
        q0.delete();
        for (int i = 0; i < 4; i++) for (int k = 0; k < T; k++) h0[i][k] = 0;
        nb = nout0;
        @(negedge clk);
        rst0 = 1'b0;
        clear_len(0, 16, "reset_clear_len0");
        chk("reset_no_output", nout0 - nb, 0);
        send(0, 0, 1, 1'b0, 0, 0);
        drain();

        // Narrowing to 16 bits: full-scale input on every tap
        for (int k = 0; k < T; k++) wcoef(1, k, 32767, 1'b1);
        for (int i = 0; i < 4; i++) send(1, 0, 32767, 1'b0, 0, 0);
        drain();

        // Invalid channel is consumed with no output and no history effect
        nb = nout1;
        send(1, 3, 55, 1'b0, 0, 0);
        chk("invalid_ready", rdy1, 1);
        repeat (T + 6) @(negedge clk);
        chk("invalid_no_output", nout1 - nb, 0);
        send(1, 0, 0, 1'b0, 0, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
